// File: rtl/control_pkg.sv
// Shared opcodes, branch condition codes and sequencer state encoding
// for the control unit and its helpers.
package control_pkg;

  localparam logic [3:0] OP_ALU_MAX = 4'h9;
  localparam logic [3:0] OP_ALUI    = 4'hA;
  localparam logic [3:0] OP_LD      = 4'hB;
  localparam logic [3:0] OP_ST      = 4'hC;
  localparam logic [3:0] OP_BR      = 4'hD;
  localparam logic [3:0] OP_HALT    = 4'hE;
  localparam logic [3:0] OP_NOP     = 4'hF;

  localparam logic [3:0] CC_ALWAYS = 4'h0;
  localparam logic [3:0] CC_Z      = 4'h1;
  localparam logic [3:0] CC_NZ     = 4'h2;
  localparam logic [3:0] CC_N      = 4'h3;
  localparam logic [3:0] CC_C      = 4'h4;
  localparam logic [3:0] CC_V      = 4'h5;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_IMMF,
    S_IMMD,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } flags_t;

endpackage

// File: rtl/control_unit_cond_eval.sv
// Branch condition evaluation against the latched V/C/N/Z flags.
// Codes above V are reserved and never taken.
module cond_eval
  import control_pkg::*;
(
  input  logic [3:0] i_cond,
  input  flags_t     i_flags,
  output logic       o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      CC_ALWAYS: o_taken = 1'b1;
      CC_Z:      o_taken = i_flags.z;
      CC_NZ:     o_taken = ~i_flags.z;
      CC_N:      o_taken = i_flags.n;
      CC_C:      o_taken = i_flags.c;
      CC_V:      o_taken = i_flags.v;
      default:   o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: fetch/decode, optional immediate word,
// one control word per instruction, and the data-memory req/ack handshake.
module control_unit
  import control_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        V,
  input  logic        C,
  input  logic        N,
  input  logic        Z,
  output logic        load_en,
  output logic [3:0]  A_sel,
  output logic [3:0]  B_sel,
  output logic [3:0]  dest_sel,
  output logic [3:0]  op_sel,
  output logic        const_sel,
  output logic [15:0] const_in,
  output logic        data_sel,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        halted
);

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_imm;
  flags_t      r_flags;

  logic [3:0]  w_op;
  logic [3:0]  w_d;
  logic [3:0]  w_a;
  logic [3:0]  w_b;
  logic [15:0] w_offset;
  logic        w_taken;
  logic        w_is_alu;

  assign w_op      = r_ir[15:12];
  assign w_d       = r_ir[11:8];
  assign w_a       = r_ir[7:4];
  assign w_b       = r_ir[3:0];
  assign w_offset  = {{8{r_ir[7]}}, r_ir[7:0]};
  assign w_is_alu  = (w_op <= OP_ALU_MAX);
  assign imem_addr = r_pc;

  cond_eval u_cond_eval (
    .i_cond  (w_d),
    .i_flags (r_flags),
    .o_taken (w_taken)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= 16'hF000;
      r_imm   <= 16'h0000;
      r_flags <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_DECODE: begin
          r_ir <= imem_data;
          r_pc <= r_pc + 16'd1;
        end
        S_IMMD: begin
          r_imm <= imem_data;
          r_pc  <= r_pc + 16'd1;
        end
        S_EXEC: begin
          if (w_is_alu || (w_op == OP_ALUI))
            r_flags <= '{v: V, c: C, n: N, z: Z};
          // PC already points past the branch word here
          if ((w_op == OP_BR) && w_taken)
            r_pc <= r_pc + w_offset;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    load_en      = 1'b0;
    A_sel        = 4'h0;
    B_sel        = 4'h0;
    dest_sel     = 4'h0;
    op_sel       = 4'h0;
    const_sel    = 1'b0;
    const_in     = 16'h0000;
    data_sel     = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    halted       = 1'b0;
    case (r_state)
      S_FETCH:  w_state_next = S_DECODE;
      S_DECODE: w_state_next = (imem_data[15:12] == OP_ALUI) ? S_IMMF : S_EXEC;
      S_IMMF:   w_state_next = S_IMMD;
      S_IMMD:   w_state_next = S_EXEC;
      S_EXEC: begin
        w_state_next = S_FETCH;
        if (w_is_alu) begin
          op_sel   = w_op;
          A_sel    = w_a;
          B_sel    = w_b;
          dest_sel = w_d;
          load_en  = 1'b1;
        end else begin
          case (w_op)
            OP_ALUI: begin
              op_sel    = w_b;
              A_sel     = w_a;
              dest_sel  = w_d;
              const_sel = 1'b1;
              const_in  = r_imm;
              load_en   = 1'b1;
            end
            OP_LD: begin
              A_sel        = w_a;
              dest_sel     = w_d;
              data_sel     = 1'b1;
              mem_req      = 1'b1;
              w_state_next = S_MEM;
            end
            OP_ST: begin
              A_sel        = w_a;
              B_sel        = w_b;
              mem_req      = 1'b1;
              mem_we       = 1'b1;
              w_state_next = S_MEM;
            end
            OP_HALT: w_state_next = S_HALT;
            default: ;
          endcase
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        A_sel   = w_a;
        if (w_op == OP_LD) begin
          dest_sel = w_d;
          data_sel = 1'b1;
          load_en  = mem_ack;
        end else begin
          B_sel  = w_b;
          mem_we = 1'b1;
        end
        if (mem_ack)
          w_state_next = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: w_state_next = S_FETCH;
    endcase
  end

endmodule
